// File: rtl/bcrypt_pkg.sv
// Shared types and sizes for the bcrypt key buffer.
// Key image geometry, FSM states and the byte type.
package bcrypt_pkg;

   localparam int KEY_MAX_BYTES = 72;
   localparam int KEY_WIN = 8;

   typedef enum logic [2:0] {
      KB_IDLE,
      KB_LOAD,
      KB_PAD,
      KB_EXPAND,
      KB_READY
   } kbuf_state_t;

   typedef logic [7:0] key_byte_t;

endpackage

// File: rtl/bcrypt_key_buffer_key_window_mux.sv
// 8-byte combinational window read from the key image.
// Indices past the end of the image read as zero.
module key_window_mux
   import bcrypt_pkg::*;
(
   input  key_byte_t  image [KEY_MAX_BYTES],
   input  logic [6:0] key_addr,
   output key_byte_t  key_data [KEY_WIN]
);

   for (genvar k = 0; k < KEY_WIN; k++) begin : g_win
      logic [7:0] idx;
      assign idx = {1'b0, key_addr} + 8'(k);
      assign key_data[k] = (idx < 8'(KEY_MAX_BYTES))
                           ? image[idx[6:0]] : 8'h00;
   end

endmodule

// File: rtl/bcrypt_key_buffer.sv
// Captures a password, appends the NUL terminator and
// expands it cyclically into a 72-byte image for key expansion.
module bcrypt_key_buffer
   import bcrypt_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       load,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic       in_end,
   input  logic [6:0] key_addr,
   output key_byte_t  key_data [KEY_WIN],
   output logic [6:0] key_len,
   output logic       truncated,
   output logic       key_ready
);

   localparam logic [6:0] MAX7 = 7'(KEY_MAX_BYTES);

   kbuf_state_t state, state_next;
   key_byte_t   image [KEY_MAX_BYTES];
   logic [6:0]  n, dst, src;
   logic [6:0]  len_next;

   // Cyclic length including the terminator, capped at the image size.
   assign len_next = (n == MAX7) ? MAX7 : n + 7'd1;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= KB_IDLE;
      else       state <= state_next;
   end

   // Next-state and handshake outputs; load restarts from any state.
   always_comb begin
      state_next = state;
      in_ready   = 1'b0;
      key_ready  = 1'b0;
      unique case (state)
         KB_IDLE: ;
         KB_LOAD: begin
            in_ready = 1'b1;
            if (in_end) state_next = KB_PAD;
         end
         KB_PAD:
            state_next = (len_next == MAX7) ? KB_READY : KB_EXPAND;
         KB_EXPAND:
            if (dst == MAX7 - 7'd1) state_next = KB_READY;
         KB_READY:
            key_ready = 1'b1;
         default:
            state_next = KB_IDLE;
      endcase
      if (load) state_next = KB_LOAD;
   end

   // Image capture, terminator, and the src->dst cyclic copy.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         n         <= '0;
         dst       <= '0;
         src       <= '0;
         key_len   <= '0;
         truncated <= 1'b0;
         for (int i = 0; i < KEY_MAX_BYTES; i++) image[i] <= 8'h00;
      end else if (load) begin
         n         <= '0;
         truncated <= 1'b0;
      end else begin
         unique case (state)
            KB_LOAD: begin
               if (in_valid) begin
                  if (n < MAX7) begin
                     image[n] <= in_data;
                     n        <= n + 7'd1;
                  end else begin
                     truncated <= 1'b1;
                  end
               end
            end
            KB_PAD: begin
               if (n < MAX7) image[n] <= 8'h00;
               key_len <= len_next;
               dst     <= len_next;
               src     <= '0;
            end
            KB_EXPAND: begin
               image[dst] <= image[src];
               dst        <= dst + 7'd1;
               src        <= src + 7'd1;
            end
            default: ;
         endcase
      end
   end

   key_window_mux u_mux (
      .image    (image),
      .key_addr (key_addr),
      .key_data (key_data)
   );

endmodule

// File: tb/tb_bcrypt_key_buffer.sv
// Bench for bcrypt_key_buffer: directed and random passwords
// compared against a cyclic-image model built from the byte list.
module tb_bcrypt_key_buffer;
   import bcrypt_pkg::*;

   logic       clk = 1'b0;
   logic       reset, load, in_valid, in_end;
   logic [7:0] in_data;
   logic [6:0] key_addr;
   key_byte_t  key_data [KEY_WIN];
   logic       in_ready, truncated, key_ready;
   logic [6:0] key_len;

   int vectors = 0;
   int miscompares = 0;

   byte unsigned acc[$];
   byte unsigned pw[$];
   int offered;

   always #5 clk = ~clk;

   bcrypt_key_buffer dut (
      .clk       (clk),
      .reset     (reset),
      .load      (load),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .in_end    (in_end),
      .key_addr  (key_addr),
      .key_data  (key_data),
      .key_len   (key_len),
      .truncated (truncated),
      .key_ready (key_ready)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int model_len();
      return (offered >= KEY_MAX_BYTES) ? KEY_MAX_BYTES : offered + 1;
   endfunction

   // Password bytes then a NUL, repeated with period L, zero past the end.
   function automatic logic [7:0] model_byte(input int idx);
      int j;
      if (idx >= KEY_MAX_BYTES) return 8'h00;
      j = idx % model_len();
      return (j < acc.size()) ? acc[j] : 8'h00;
   endfunction

   task automatic begin_load();
      in_valid = 1'b0;
      in_end   = 1'b0;
      @(negedge clk) load = 1'b1;
      @(negedge clk) load = 1'b0;
      acc.delete();
      offered = 0;
   endtask

   task automatic feed(input bit end_last, input bit gaps);
      for (int i = 0; i < pw.size(); i++) begin
         if (gaps && $urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            in_end   = 1'b0;
            @(negedge clk);
         end
         in_valid = 1'b1;
         in_data  = pw[i];
         in_end   = end_last && (i == pw.size() - 1);
         offered++;
         if (acc.size() < KEY_MAX_BYTES) acc.push_back(pw[i]);
         @(negedge clk);
      end
      in_valid = 1'b0;
      if (!(end_last && pw.size() > 0)) begin
         in_end = 1'b1;
         @(negedge clk);
      end
      in_end = 1'b0;
   endtask

   task automatic wait_ready(input string tag);
      int cyc = 0;
      while (!key_ready && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, cyc, 1 + KEY_MAX_BYTES - model_len());
   endtask

   task automatic check_windows(input string tag);
      int a;
      check({tag, " key_len"}, key_len, model_len());
      check({tag, " truncated"}, truncated, offered > KEY_MAX_BYTES);
      check({tag, " key_ready"}, key_ready, 1);
      check({tag, " in_ready"}, in_ready, 0);
      for (int w = 0; w <= 10; w++) begin
         a = (w == 10) ? 66 : w * 8;
         key_addr = 7'(a);
         #1;
         for (int k = 0; k < KEY_WIN; k++)
            check($sformatf("%s win%0d[%0d]", tag, a, k),
                  key_data[k], model_byte(a + k));
         @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1; load = 1'b0; in_valid = 1'b0; in_end = 1'b0;
      in_data = 8'h00; key_addr = 7'd0;
      offered = 0;
      #12;
      check("rst in_ready", in_ready, 0);
      check("rst key_ready", key_ready, 0);
      check("rst key_len", key_len, 0);
      check("rst truncated", truncated, 0);
      for (int k = 0; k < KEY_WIN; k++)
         check("rst key_data", key_data[k], 8'h00);
      @(negedge clk) reset = 1'b0;

      begin_load();
      check("load in_ready", in_ready, 1);
      pw = '{8'h61, 8'h62, 8'h63};
      feed(1'b1, 1'b0);
      wait_ready("abc");
      check("abc len const", key_len, 4);
      key_addr = 7'd8;
      #1;
      check("abc w8[3] const", key_data[3], 8'h00);
      check("abc w8[4] const", key_data[4], 8'h61);
      @(negedge clk);
      check_windows("abc");

      begin_load();
      pw = '{8'h61, 8'h62, 8'h63, 8'h64};
      feed(1'b0, 1'b0);
      wait_ready("abcd");
      key_addr = 7'd64;
      #1;
      check("abcd w64[0] const", key_data[0], 8'h00);
      check("abcd w64[1] const", key_data[1], 8'h61);
      @(negedge clk);
      check_windows("abcd");

      begin_load();
      pw.delete();
      feed(1'b1, 1'b0);
      wait_ready("empty");
      check_windows("empty");

      begin_load();
      pw.delete();
      for (int i = 1; i <= 72; i++) pw.push_back(8'(i));
      feed(1'b1, 1'b0);
      wait_ready("b72");
      check_windows("b72");

      begin_load();
      pw.delete();
      for (int i = 1; i <= 75; i++) pw.push_back(8'(i));
      feed(1'b1, 1'b0);
      wait_ready("b75");
      check("b75 truncated const", truncated, 1);
      check_windows("b75");

      in_valid = 1'b1; in_data = 8'hff; in_end = 1'b1;
      repeat (3) @(negedge clk);
      in_valid = 1'b0; in_end = 1'b0;
      check_windows("ignored");

      begin_load();
      pw = '{8'h61, 8'h62, 8'h63};
      feed(1'b1, 1'b0);
      repeat (10) @(negedge clk);
      check("midexp busy", key_ready, 0);
      @(negedge clk) load = 1'b1;
      @(negedge clk) load = 1'b0;
      acc.delete();
      offered = 0;
      check("midexp in_ready", in_ready, 1);
      repeat (80) @(negedge clk);
      check("midexp stays", key_ready, 0);
      pw = '{8'h78, 8'h79};
      feed(1'b1, 1'b0);
      wait_ready("xy");
      check_windows("xy");

      for (int t = 0; t < 8; t++) begin
         begin_load();
         pw.delete();
         for (int i = $urandom_range(0, 80); i > 0; i--)
            pw.push_back(8'($urandom));
         feed(1'($urandom), 1'b1);
         wait_ready($sformatf("rnd%0d", t));
         check_windows($sformatf("rnd%0d", t));
      end

      begin_load();
      in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = 8'hA0 + 8'(i);
         @(negedge clk);
      end
      in_valid = 1'b0;
      #2 reset = 1'b1;
      #1;
      check("arst in_ready", in_ready, 0);
      check("arst key_ready", key_ready, 0);
      check("arst key_len", key_len, 0);
      check("arst truncated", truncated, 0);
      key_addr = 7'd0;
      #1;
      for (int k = 0; k < KEY_WIN; k++)
         check("arst key_data", key_data[k], 8'h00);
      @(negedge clk) reset = 1'b0;
      @(negedge clk);
      check("arst idle", in_ready, 0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
